// File: rtl/arc4_pkg.sv
// Shared ARC4 datapath constants and the state type for the S-array permutation checker.
package arc4_pkg;

    localparam int ARC4_ADDR_W = 8;
    localparam int ARC4_DATA_W = 8;
    localparam int ARC4_DEPTH  = 256;

    // Sum of 0..255 in 16 bits: the checksum any valid permutation must produce.
    localparam logic [15:0] PERM_CSUM_IDENT = 16'h7F80;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } perm_state_t;

endpackage

// File: rtl/s_perm_check_bitmap.sv
// s_seen_bitmap: one flag per byte value with synchronous clear and set.
// hit reports the flag for idx before any set in the same cycle.
module s_seen_bitmap
    import arc4_pkg::*;
#(
    parameter int IDX_W = ARC4_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             set_en,
    input  logic [IDX_W-1:0] idx,
    output logic             hit
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] seen;

    assign hit = seen[idx];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            seen <= '0;
        end else if (set_en) begin
            seen[idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/s_perm_check.sv
// Scans s_mem and reports whether it holds a permutation of 0..255 plus a wrapping byte sum.
// Optional S_PERM_CHECK_DUP_ADDR_EN adds dup_addr/dup_valid naming the first repeated read.
//
// en/rdy handshake: a scan starts on a rising edge where rdy=1 and en=1; rdy drops
// the next cycle and returns with the one-cycle valid pulse; en while rdy=0 is ignored.
module s_perm_check
    import arc4_pkg::*;
#(
    parameter int ADDR_W = ARC4_ADDR_W,
    parameter int DATA_W = ARC4_DATA_W,
    parameter int CSUM_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rddata,
    output logic              valid,
    output logic              is_perm,
    output logic [CSUM_W-1:0] checksum,
`ifdef S_PERM_CHECK_DUP_ADDR_EN
    output logic [ADDR_W-1:0] dup_addr,
    output logic              dup_valid,
`endif
    output perm_state_t       dbg_state
);

    perm_state_t       state;
    logic              start;
    logic              cap_v;
    logic              hit;
    logic              first_dup;
    logic              dup;
    logic              dup_nxt;
    logic [CSUM_W-1:0] acc;
    logic [CSUM_W-1:0] acc_nxt;

    assign dbg_state = state;
    // rdy is high exactly in IDLE and DONE, so it doubles as the accept qualifier.
    assign start     = rdy && en;
    assign first_dup = cap_v && hit && !dup;

    always_comb begin
        acc_nxt = acc;
        dup_nxt = dup;
        if (cap_v) begin
            acc_nxt = acc + CSUM_W'(rddata);
        end
        if (first_dup) begin
            dup_nxt = 1'b1;
        end
    end

    s_seen_bitmap #(
        .IDX_W(DATA_W)
    ) u_seen (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .set_en(cap_v),
        .idx   (rddata),
        .hit   (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rdy      <= 1'b1;
            valid    <= 1'b0;
            addr     <= '0;
            is_perm  <= 1'b0;
            checksum <= '0;
            cap_v    <= 1'b0;
            acc      <= '0;
            dup      <= 1'b0;
        end else begin
            // rddata in the next cycle answers the address issued in this one.
            cap_v <= (state == READ);
            acc   <= acc_nxt;
            dup   <= dup_nxt;
            valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= READ;
                        rdy   <= 1'b0;
                        addr  <= '0;
                        acc   <= '0;
                        dup   <= 1'b0;
                    end else begin
                        state <= IDLE;
                        rdy   <= 1'b1;
                    end
                end
                READ: begin
                    addr <= addr + 1'b1;
                    if (addr == '1) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Last byte is folded in via the *_nxt terms in this same cycle.
                    state    <= DONE;
                    rdy      <= 1'b1;
                    valid    <= 1'b1;
                    is_perm  <= ~dup_nxt;
                    checksum <= acc_nxt;
                end
                default: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                end
            endcase
        end
    end

`ifdef S_PERM_CHECK_DUP_ADDR_EN
    logic [ADDR_W-1:0] cap_addr;
    logic [ADDR_W-1:0] dup_at;

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_addr  <= '0;
            dup_at    <= '0;
            dup_addr  <= '0;
            dup_valid <= 1'b0;
        end else begin
            cap_addr <= addr;
            if (start) begin
                dup_at <= '0;
            end else if (first_dup) begin
                dup_at <= cap_addr;
            end
            if (state == DRAIN) begin
                dup_valid <= dup_nxt;
                dup_addr  <= first_dup ? cap_addr : dup_at;
            end
        end
    end
`endif

endmodule
